mm_array: RTL and testbench
===========================

Name: mm_array

Overview:
Parametrised associative match-memory array. It is the successor to the fixed 16-entry, 28-bit-key, 32-bit-data match unit. Entries hold {key, data} pairs. Writes allocate entries automatically (update-in-place, then first free, then round-robin eviction). Lookups are registered with a one-cycle result and priority-encoded hit index. Key invalidate and whole-array flush are supported. It sits between the token front-end and the firing logic as the operand-matching store.

Parameters:
KEY_W, 28, key width in bits
DATA_W, 32, data width in bits
DEPTH, 16, number of entries (2..64)
IDX_W, 4, index width; must equal clog2(DEPTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
lk_req  in  1  lookup request
lk_key  in  KEY_W  lookup key
rs_valid  out  1  lookup result valid (1 cycle after lk_req)
rs_hit  out  1  OR of per-entry match
rs_multi  out  1  more than one entry matched
rs_idx  out  IDX_W  lowest matching index (0 on miss)
rs_data  out  DATA_W  data of entry rs_idx (0 on miss)
rs_vec  out  DEPTH  per-entry match vector
wr_req  in  1  write request
wr_key  in  KEY_W  write key
wr_data  in  DATA_W  write data
wr_ack  out  1  write done pulse (1 cycle after wr_req)
wr_idx  out  IDX_W  entry written
wr_evict  out  1  write replaced a valid entry with a different key
inv_req  in  1  invalidate all entries matching inv_key
inv_key  in  KEY_W  invalidate key
inv_ack  out  1  invalidate done pulse
inv_hit  out  1  at least one entry was invalidated
flush  in  1  clear all valid bits
count  out  IDX_W+1  number of valid entries
full  out  1  count == DEPTH

Behaviour:
- Reset (rst low, async): all valid bits 0, victim pointer 0. All outputs 0 except full=0 and count=0. Key/data storage is not reset.
- Match: entry i matches key K iff valid[i] && key[i]==K.
- Lookup: on a sampled lk_req, next cycle rs_valid=1 with rs_hit, rs_multi, rs_idx, rs_data and rs_vec computed from pre-edge contents. Lookup is read-before-write: a same-cycle write or invalidate is not visible. Without lk_req, rs_valid=0 and other rs_* hold their last values.
- Request priority per cycle: flush > wr_req > inv_req. A lower-priority request in the same cycle is dropped, and its ack stays 0. Lookup is independent of this priority.
- Write allocation, evaluated on pre-edge contents:
  (a) If any entry matches wr_key, the lowest matching index is updated; wr_evict=0.
  (b) Otherwise, the lowest-index invalid entry is used; wr_evict=0.
  (c) Otherwise (full), the entry at the victim pointer is overwritten; wr_evict=1. The pointer then increments modulo DEPTH.
  The victim pointer changes only in case (c). In every case the target's valid bit is set, and wr_ack/wr_idx/wr_evict are registered one cycle later.
- Invalidate: clears valid on every matching entry. inv_ack pulses next cycle; inv_hit=1 iff the match vector was nonzero.
- Flush: clears all valid bits at the edge. It does not ack and does not move the victim pointer.
- count/full: registered and consistent with valid bits after each edge. Write case (a) does not change count, case (b) adds 1, case (c) does not change it. Invalidate subtracts the popcount of matches; flush sets count to 0.
- Reset asserted mid-operation aborts pending acks and results; no ack follows reset release.

Test Plan:
- Reset, then lookup key 0x000_0000 -> rs_valid=1, rs_hit=0, rs_idx=0, rs_data=0, count=0.
- Write keys 0x1..0x10 with data 0xA0+k (DEPTH=16) -> wr_idx 0..15, wr_evict=0; full=1, count=16 after the last write.
- Write key 0x11 with data 0xFF while full -> wr_idx=0, wr_evict=1. Next write key 0x12 -> wr_idx=1. Lookup 0x1 -> miss; lookup 0x11 -> hit, rs_idx=0, rs_data=0xFF.
- Write key 0x5 with data 0x55 while lookup 0x5 in the same cycle -> lookup returns old data 0xA5. A following lookup returns 0x55, wr_idx=4, count unchanged.
- Invalidate key 0x7 -> inv_ack=1, inv_hit=1, count decreases by 1. Next write of new key 0x20 lands at index 6 (lowest free).
- Assert flush, wr_req and inv_req together -> no wr_ack or inv_ack, count=0. Assert rst low mid-lookup -> rs_valid=0 immediately and stays 0 after release.

Source files
------------

// File: rtl/mm_array_if.sv
// -----------------------------------------------------------------------------
// mm_array_if
// Bundles every request/response signal of the match-memory array.
//   master : requester side (token front-end / firing logic, or a bench)
//   slave  : the mm_array itself
// Signals:
//   lk_req/lk_key                      lookup request and key
//   rs_valid/rs_hit/rs_multi/rs_idx/
//   rs_data/rs_vec                     registered lookup result
//   wr_req/wr_key/wr_data              write request
//   wr_ack/wr_idx/wr_evict             registered write completion
//   inv_req/inv_key                    invalidate-by-key request
//   inv_ack/inv_hit                    registered invalidate completion
//   flush                              clear all entries
//   count/full                         occupancy status
// -----------------------------------------------------------------------------
interface mm_array_if #(
    parameter int KEY_W  = 28,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
);
    logic              lk_req;
    logic [KEY_W-1:0]  lk_key;
    logic              rs_valid;
    logic              rs_hit;
    logic              rs_multi;
    logic [IDX_W-1:0]  rs_idx;
    logic [DATA_W-1:0] rs_data;
    logic [DEPTH-1:0]  rs_vec;
    logic              wr_req;
    logic [KEY_W-1:0]  wr_key;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_evict;
    logic              inv_req;
    logic [KEY_W-1:0]  inv_key;
    logic              inv_ack;
    logic              inv_hit;
    logic              flush;
    logic [IDX_W:0]    count;
    logic              full;

    modport master (
        output lk_req, lk_key, wr_req, wr_key, wr_data, inv_req, inv_key, flush,
        input  rs_valid, rs_hit, rs_multi, rs_idx, rs_data, rs_vec,
               wr_ack, wr_idx, wr_evict, inv_ack, inv_hit, count, full
    );

    modport slave (
        input  lk_req, lk_key, wr_req, wr_key, wr_data, inv_req, inv_key, flush,
        output rs_valid, rs_hit, rs_multi, rs_idx, rs_data, rs_vec,
               wr_ack, wr_idx, wr_evict, inv_ack, inv_hit, count, full
    );
endinterface

// File: rtl/mm_array.sv
// -----------------------------------------------------------------------------
// mm_array
// Associative match memory holding {key, data} pairs, used as the operand
// matching store between the token front-end and the firing logic.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : mm_array_if.slave -- lookup / write / invalidate / flush traffic
// Writes update an existing entry with the same key, else take the lowest
// free entry, else evict the entry under a round-robin victim pointer.
// Lookups see pre-edge contents (read-before-write) and return one cycle later.
// IDX_W must equal clog2(DEPTH); DEPTH may range from 2 to 64.
// -----------------------------------------------------------------------------
module mm_array #(
    parameter int KEY_W  = 28,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    mm_array_if.slave   bus
);
    localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(DEPTH - 1);

    // Key/data storage carries no reset: only the valid bits qualify it.
    logic [KEY_W-1:0]  r_key  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [IDX_W-1:0]  r_victim;

    logic [DEPTH-1:0]  w_lk_vec;
    logic [DEPTH-1:0]  w_wr_vec;
    logic [DEPTH-1:0]  w_inv_vec;
    logic              w_do_wr;
    logic              w_do_inv;
    logic              w_wr_hit;
    logic              w_has_free;
    logic              w_wr_evict;
    logic [IDX_W-1:0]  w_wr_tgt;
    logic [IDX_W-1:0]  w_lk_idx;
    logic              w_lk_hit;
    logic [IDX_W:0]    w_inv_cnt;

    // Lowest set bit position, 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] f_lowest(input logic [DEPTH-1:0] v);
        f_lowest = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = IDX_W'(i);
        end
    endfunction

    function automatic logic [IDX_W:0] f_popcnt(input logic [DEPTH-1:0] v);
        f_popcnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            f_popcnt = f_popcnt + {{IDX_W{1'b0}}, v[i]};
        end
    endfunction

    // Three independent compare ports, one per request type.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_lk_vec[gi]  = r_valid[gi] && (r_key[gi] == bus.lk_key);
            assign w_wr_vec[gi]  = r_valid[gi] && (r_key[gi] == bus.wr_key);
            assign w_inv_vec[gi] = r_valid[gi] && (r_key[gi] == bus.inv_key);
        end
    endgenerate

    // flush outranks write, write outranks invalidate.
    assign w_do_wr    = bus.wr_req && !bus.flush;
    assign w_do_inv   = bus.inv_req && !bus.flush && !bus.wr_req;
    assign w_wr_hit   = |w_wr_vec;
    assign w_has_free = ~&r_valid;
    assign w_wr_evict = !w_wr_hit && !w_has_free;
    assign w_wr_tgt   = w_wr_hit   ? f_lowest(w_wr_vec) :
                        w_has_free ? f_lowest(~r_valid) : r_victim;
    assign w_lk_idx   = f_lowest(w_lk_vec);
    assign w_lk_hit   = |w_lk_vec;
    assign w_inv_cnt  = f_popcnt(w_inv_vec);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_key[w_wr_tgt]  <= bus.wr_key;
            r_data[w_wr_tgt] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= '0;
            r_victim     <= '0;
            bus.count    <= '0;
            bus.full     <= 1'b0;
            bus.wr_ack   <= 1'b0;
            bus.wr_idx   <= '0;
            bus.wr_evict <= 1'b0;
            bus.inv_ack  <= 1'b0;
            bus.inv_hit  <= 1'b0;
            bus.rs_valid <= 1'b0;
            bus.rs_hit   <= 1'b0;
            bus.rs_multi <= 1'b0;
            bus.rs_idx   <= '0;
            bus.rs_data  <= '0;
            bus.rs_vec   <= '0;
        end else begin
            bus.wr_ack  <= w_do_wr;
            bus.inv_ack <= w_do_inv;

            if (bus.flush) begin
                r_valid   <= '0;
                bus.count <= '0;
                bus.full  <= 1'b0;
            end else if (w_do_wr) begin
                r_valid[w_wr_tgt] <= 1'b1;
                bus.wr_idx        <= w_wr_tgt;
                bus.wr_evict      <= w_wr_evict;
                // Only allocation into a free slot grows the occupancy.
                if (!w_wr_hit && w_has_free) begin
                    bus.count <= bus.count + 1'b1;
                    bus.full  <= (bus.count + 1'b1) == DEPTH_C;
                end
                if (w_wr_evict) begin
                    r_victim <= (r_victim == LAST_C) ? '0 : r_victim + 1'b1;
                end
            end else if (w_do_inv) begin
                r_valid     <= r_valid & ~w_inv_vec;
                bus.inv_hit <= |w_inv_vec;
                bus.count   <= bus.count - w_inv_cnt;
                bus.full    <= (bus.count - w_inv_cnt) == DEPTH_C;
            end

            bus.rs_valid <= bus.lk_req;
            if (bus.lk_req) begin
                bus.rs_vec   <= w_lk_vec;
                bus.rs_hit   <= w_lk_hit;
                bus.rs_multi <= (w_lk_vec & (w_lk_vec - DEPTH'(1))) != '0;
                bus.rs_idx   <= w_lk_idx;
                bus.rs_data  <= w_lk_hit ? r_data[w_lk_idx] : '0;
            end
        end
    end
endmodule

// File: tb/tb_mm_array.sv
// -----------------------------------------------------------------------------
// tb_mm_array
// Directed scenarios followed by randomized traffic. A behavioural model of
// the store (plain arrays, searched with loops) predicts every registered
// output; a single process compares the DUT against it after each edge.
// -----------------------------------------------------------------------------
module tb_mm_array;
    localparam int KEY_W  = 28;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;

    logic clk;
    logic rst;

    mm_array_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    mm_array #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              m_valid [DEPTH];
    logic [KEY_W-1:0]  m_key   [DEPTH];
    logic [DATA_W-1:0] m_data  [DEPTH];
    int                m_victim;

    logic              e_rs_valid, e_rs_hit, e_rs_multi;
    int                e_rs_idx;
    logic [DATA_W-1:0] e_rs_data;
    logic [DEPTH-1:0]  e_rs_vec;
    logic              e_wr_ack, e_wr_evict, e_inv_ack, e_inv_hit;
    int                e_wr_idx;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin
        int tgt;
        int nm;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            m_victim   = 0;
            e_rs_valid = 1'b0;
            e_wr_ack   = 1'b0;
            e_inv_ack  = 1'b0;
        end else begin
            // Lookup against contents before this edge.
            e_rs_valid = bus.lk_req;
            if (bus.lk_req) begin
                e_rs_vec = '0;
                e_rs_idx = -1;
                nm = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_valid[i] && m_key[i] == bus.lk_key) begin
                        e_rs_vec[i] = 1'b1;
                        nm++;
                        if (e_rs_idx < 0) e_rs_idx = i;
                    end
                end
                e_rs_hit   = nm > 0;
                e_rs_multi = nm > 1;
                e_rs_data  = e_rs_hit ? m_data[e_rs_idx] : '0;
                if (e_rs_idx < 0) e_rs_idx = 0;
            end
            e_wr_ack  = 1'b0;
            e_inv_ack = 1'b0;
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end else if (bus.wr_req) begin
                tgt = -1;
                e_wr_evict = 1'b0;
                for (int i = 0; i < DEPTH && tgt < 0; i++)
                    if (m_valid[i] && m_key[i] == bus.wr_key) tgt = i;
                for (int i = 0; i < DEPTH && tgt < 0; i++)
                    if (!m_valid[i]) tgt = i;
                if (tgt < 0) begin
                    tgt = m_victim;
                    e_wr_evict = 1'b1;
                    m_victim = (m_victim + 1) % DEPTH;
                end
                m_valid[tgt] = 1'b1;
                m_key[tgt]   = bus.wr_key;
                m_data[tgt]  = bus.wr_data;
                e_wr_ack = 1'b1;
                e_wr_idx = tgt;
            end else if (bus.inv_req) begin
                e_inv_hit = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_valid[i] && m_key[i] == bus.inv_key) begin
                        m_valid[i] = 1'b0;
                        e_inv_hit  = 1'b1;
                    end
                end
                e_inv_ack = 1'b1;
            end
        end
        #1;
        chk("rs_valid", 64'(bus.rs_valid), 64'(e_rs_valid));
        if (e_rs_valid) begin
            chk("rs_hit",   64'(bus.rs_hit),   64'(e_rs_hit));
            chk("rs_multi", 64'(bus.rs_multi), 64'(e_rs_multi));
            chk("rs_idx",   64'(bus.rs_idx),   64'(e_rs_idx));
            chk("rs_data",  64'(bus.rs_data),  64'(e_rs_data));
            chk("rs_vec",   64'(bus.rs_vec),   64'(e_rs_vec));
        end
        chk("wr_ack", 64'(bus.wr_ack), 64'(e_wr_ack));
        if (e_wr_ack) begin
            chk("wr_idx",   64'(bus.wr_idx),   64'(e_wr_idx));
            chk("wr_evict", 64'(bus.wr_evict), 64'(e_wr_evict));
        end
        chk("inv_ack", 64'(bus.inv_ack), 64'(e_inv_ack));
        if (e_inv_ack) chk("inv_hit", 64'(bus.inv_hit), 64'(e_inv_hit));
        chk("count", 64'(bus.count), 64'(m_count()));
        chk("full",  64'(bus.full),  64'(m_count() == DEPTH));
    end

    // ---------------- stimulus ----------------
    task automatic clear_req();
        bus.lk_req  = 1'b0;
        bus.wr_req  = 1'b0;
        bus.inv_req = 1'b0;
        bus.flush   = 1'b0;
    endtask

    // Apply the currently driven requests for one edge, then release them.
    task automatic step();
        @(posedge clk);
        #2;
        clear_req();
    endtask

    task automatic do_wr(input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d);
        bus.wr_req  = 1'b1;
        bus.wr_key  = k;
        bus.wr_data = d;
        step();
    endtask

    task automatic do_lk(input logic [KEY_W-1:0] k);
        bus.lk_req = 1'b1;
        bus.lk_key = k;
        step();
    endtask

    initial begin
        rst = 1'b0;
        clear_req();
        bus.lk_key = '0; bus.wr_key = '0; bus.wr_data = '0; bus.inv_key = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        chk("lit_reset_count", 64'(bus.count), 64'd0);
        chk("lit_reset_full",  64'(bus.full),  64'd0);

        do_lk('0);
        chk("lit_lk0_valid", 64'(bus.rs_valid), 64'd1);
        chk("lit_lk0_hit",   64'(bus.rs_hit),   64'd0);
        chk("lit_lk0_data",  64'(bus.rs_data),  64'd0);

        for (int k = 1; k <= 16; k++) begin
            do_wr(KEY_W'(k), DATA_W'(32'hA0 + k));
            chk("lit_fill_idx", 64'(bus.wr_idx), 64'(k - 1));
        end
        chk("lit_fill_full",  64'(bus.full),  64'd1);
        chk("lit_fill_count", 64'(bus.count), 64'd16);

        do_wr(28'h11, 32'hFF);
        chk("lit_evict_idx", 64'(bus.wr_idx),   64'd0);
        chk("lit_evict_bit", 64'(bus.wr_evict), 64'd1);
        do_wr(28'h12, 32'hEE);
        chk("lit_evict2_idx", 64'(bus.wr_idx), 64'd1);
        do_lk(28'h1);
        chk("lit_lk1_hit", 64'(bus.rs_hit), 64'd0);
        do_lk(28'h11);
        chk("lit_lk11_idx",  64'(bus.rs_idx),  64'd0);
        chk("lit_lk11_data", 64'(bus.rs_data), 64'hFF);

        bus.lk_req = 1'b1;
        bus.lk_key = 28'h5;
        do_wr(28'h5, 32'h55);
        chk("lit_rbw_data", 64'(bus.rs_data), 64'hA5);
        chk("lit_rbw_idx",  64'(bus.wr_idx),  64'd4);
        chk("lit_rbw_count", 64'(bus.count),  64'd16);
        do_lk(28'h5);
        chk("lit_new_data", 64'(bus.rs_data), 64'h55);

        bus.inv_req = 1'b1;
        bus.inv_key = 28'h7;
        step();
        chk("lit_inv_ack",   64'(bus.inv_ack), 64'd1);
        chk("lit_inv_hit",   64'(bus.inv_hit), 64'd1);
        chk("lit_inv_count", 64'(bus.count),   64'd15);
        do_wr(28'h20, 32'h20);
        chk("lit_free_idx", 64'(bus.wr_idx), 64'd6);

        bus.flush = 1'b1;
        bus.wr_req = 1'b1; bus.wr_key = 28'h30;
        bus.inv_req = 1'b1; bus.inv_key = 28'h20;
        step();
        chk("lit_flush_wrack",  64'(bus.wr_ack),  64'd0);
        chk("lit_flush_invack", 64'(bus.inv_ack), 64'd0);
        chk("lit_flush_count",  64'(bus.count),   64'd0);

        // Randomized traffic over a small key space to force hits and evictions.
        for (int n = 0; n < 3000; n++) begin
            bus.lk_req  = ($urandom_range(0, 99) < 50);
            bus.lk_key  = KEY_W'($urandom_range(0, 23));
            bus.wr_req  = ($urandom_range(0, 99) < 45);
            bus.wr_key  = KEY_W'($urandom_range(0, 23));
            bus.wr_data = $urandom;
            bus.inv_req = ($urandom_range(0, 99) < 20);
            bus.inv_key = KEY_W'($urandom_range(0, 23));
            bus.flush   = ($urandom_range(0, 199) == 0);
            step();
        end

        // Reset in the middle of an outstanding lookup.
        do_wr(28'h3, 32'h33);
        bus.lk_req = 1'b1;
        bus.lk_key = 28'h3;
        bus.wr_req = 1'b1;
        bus.wr_key = 28'h4;
        @(posedge clk);
        #2;
        chk("lit_prerst_valid", 64'(bus.rs_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("lit_rst_valid", 64'(bus.rs_valid), 64'd0);
        chk("lit_rst_wrack", 64'(bus.wr_ack),   64'd0);
        chk("lit_rst_count", 64'(bus.count),    64'd0);
        @(posedge clk);
        #2;
        clear_req();
        rst = 1'b1;
        step();
        chk("lit_post_valid", 64'(bus.rs_valid), 64'd0);
        chk("lit_post_wrack", 64'(bus.wr_ack),   64'd0);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
